// File: rtl/schnorr_verify_core.sv
// Schnorr verifier: checks G^s == R * PUB^c (mod P) with a right-to-left square-and-multiply datapath.
// Define VERIFY_RANGE_CHECK_EN to reject out-of-range s, R and PUB at start capture.
`timescale 1ns/1ps
module schnorr_verify_core #(
  parameter int unsigned    LEN = 32,
  parameter int unsigned    SW  = LEN,
  parameter int unsigned    CW  = 16,
  parameter logic [LEN-1:0] P   = LEN'(64'd2147483647),
  parameter logic [LEN-1:0] G   = LEN'(64'd7),
  parameter logic [LEN-1:0] Q   = LEN'(64'd2147483646)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           start,
  input  logic [LEN-1:0] s_in,
  input  logic [LEN-1:0] pub_in,
  input  logic [LEN-1:0] r_in,
  input  logic [CW-1:0]  chall_in,
  output logic           busy,
  output logic           done,
  output logic           valid,
  output logic           err
);

  localparam int unsigned MW      = 2 * LEN;
  localparam int unsigned CNT_MAX = (SW > CW) ? SW : CW;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, EXP_S, EXP_C, MUL, CMP} state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    s_q, s_d;
  logic [CW-1:0]    c_q, c_d;
  logic [LEN-1:0]   pub_q, pub_d, r_q, r_d;
  logic [LEN-1:0]   acc_q, acc_d, base_q, base_d;
  logic [LEN-1:0]   sl_q, sl_d, sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             valid_q, valid_d, err_q, err_d;

  logic             exp_bit;
  logic [LEN-1:0]   acc_step;
  logic [LEN-1:0]   base_sq;
  logic             range_bad;

  // Full double-width product reduced mod P.
  function automatic logic [LEN-1:0] mod_mul(input logic [LEN-1:0] a, input logic [LEN-1:0] b);
    logic [MW-1:0] prod;
    prod = MW'(a) * MW'(b);
    return LEN'(prod % MW'(P));
  endfunction

  always_comb begin
    exp_bit  = (state_q == EXP_C) ? c_q[0] : s_q[0];
    acc_step = exp_bit ? mod_mul(acc_q, base_q) : acc_q;
    base_sq  = mod_mul(base_q, base_q);
`ifdef VERIFY_RANGE_CHECK_EN
    range_bad = (s_in >= Q) || (r_in == '0) || (r_in >= P) ||
                (pub_in == '0) || (pub_in >= P);
`else
    range_bad = 1'b0;
`endif
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    pub_d   = pub_q;
    r_d     = r_q;
    acc_d   = acc_q;
    base_d  = base_q;
    sl_d    = sl_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    err_d   = err_q;

    if (clear) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            s_d     = SW'(s_in);
            c_d     = chall_in;
            pub_d   = mod_mul(pub_in, LEN'(1));
            r_d     = mod_mul(r_in, LEN'(1));
            acc_d   = LEN'(1);
            base_d  = G;
            cnt_d   = '0;
            valid_d = 1'b0;
            err_d   = range_bad;
            busy_d  = 1'b1;
            state_d = range_bad ? CMP : EXP_S;
          end
        end
        EXP_S: begin
          acc_d  = acc_step;
          base_d = base_sq;
          s_d    = s_q >> 1;
          if (cnt_q == CNT_W'(SW - 1)) begin
            sl_d    = acc_step;
            acc_d   = LEN'(1);
            base_d  = pub_q;
            cnt_d   = '0;
            state_d = EXP_C;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        EXP_C: begin
          acc_d  = acc_step;
          base_d = base_sq;
          c_d    = c_q >> 1;
          if (cnt_q == CNT_W'(CW - 1)) begin
            cnt_d   = '0;
            state_d = MUL;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        MUL: begin
          sr_d    = mod_mul(r_q, acc_q);
          state_d = CMP;
        end
        CMP: begin
          valid_d = !err_q && (sl_q == sr_q);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      c_q     <= '0;
      pub_q   <= '0;
      r_q     <= '0;
      acc_q   <= '0;
      base_q  <= '0;
      sl_q    <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      pub_q   <= pub_d;
      r_q     <= r_d;
      acc_q   <= acc_d;
      base_q  <= base_d;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign valid = valid_q;
  assign err   = err_q;

endmodule

// File: tb/tb_schnorr_verify_core.sv
// Directed bench for schnorr_verify_core: small P=23 instance plus a default-parameter instance.
`timescale 1ns/1ps
module tb_schnorr_verify_core;

`ifdef VERIFY_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif
  localparam longint unsigned BP = 64'd2147483647;
  localparam longint unsigned BQ = 64'd2147483646;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  s_in = '0, pub_in = '0, r_in = '0;
  logic [3:0]  chall_in = '0;
  logic        busy, done, valid, err;

  logic        bclear = 1'b0;
  logic        bstart = 1'b0;
  logic [31:0] bs = '0, bpub = '0, br = '0;
  logic [15:0] bc = '0;
  logic        bbusy, bdone, bvalid, berr;

  int n_checks = 0;
  int n_errors = 0;

  schnorr_verify_core #(.LEN(8), .SW(8), .CW(4), .P(8'd23), .G(8'd4), .Q(8'd11)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .start(start),
    .s_in(s_in), .pub_in(pub_in), .r_in(r_in), .chall_in(chall_in),
    .busy(busy), .done(done), .valid(valid), .err(err)
  );

  schnorr_verify_core u_big (
    .clk(clk), .rst_n(rst_n), .clear(bclear), .start(bstart),
    .s_in(bs), .pub_in(bpub), .r_in(br), .chall_in(bc),
    .busy(bbusy), .done(bdone), .valid(bvalid), .err(berr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint unsigned modpow(input longint unsigned b, input longint unsigned e,
                                             input longint unsigned m);
    longint unsigned r, x, k;
    r = 1; x = b % m; k = e;
    while (k != 0) begin
      if (k[0]) r = (r * x) % m;
      x = (x * x) % m;
      k = k >> 1;
    end
    return r;
  endfunction

  // Drive operands, pulse start; returns just after the capture edge.
  task automatic launch(input logic [7:0] s, input logic [7:0] pub, input logic [7:0] r,
                        input logic [3:0] c, input bit hold);
    @(negedge clk);
    s_in = s; pub_in = pub; r_in = r; chall_in = c; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    bcnt = busy ? 1 : 0;
    lat  = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  task automatic run(input string tag, input logic [7:0] s, input logic [7:0] pub,
                     input logic [7:0] r, input logic [3:0] c,
                     input bit exp_valid, input bit exp_err, input int exp_lat);
    int lat, bcnt;
    launch(s, pub, r, c, 1'b0);
    wait_done(lat, bcnt);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy"}, bcnt, exp_lat);
    check({tag, "_valid"}, valid, exp_valid);
    check({tag, "_err"}, err, exp_err);
    @(posedge clk); #1;
    check({tag, "_done1"}, done, 1'b0);
  endtask

  task automatic run_big(input string tag, input longint unsigned s, input longint unsigned pub,
                         input longint unsigned r, input longint unsigned c, input bit exp_valid);
    int lat;
    @(negedge clk);
    bs = 32'(s); bpub = 32'(pub); br = 32'(r); bc = 16'(c); bstart = 1'b1;
    @(posedge clk); #1;
    bstart = 1'b0;
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (bdone) begin
        lat = i;
        break;
      end
    end
    check({tag, "_lat"}, lat, 50);
    check({tag, "_valid"}, bvalid, exp_valid);
    check({tag, "_err"}, berr, 1'b0);
  endtask

  initial begin
    int lat, bcnt, npulse;
    longint unsigned bx, bk, bcc, bsig, bpk, brr;

    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", valid, 1'b0);
    check("rst_err", err, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Good / bad signatures and degenerate exponents.
    run("good", 8'd4, 8'd18, 8'd12, 4'd7, 1'b1, 1'b0, 14);
    run("bad", 8'd5, 8'd18, 8'd12, 4'd7, 1'b0, 1'b0, 14);
    run("zero_exp", 8'd0, 8'd5, 8'd1, 4'd0, 1'b1, 1'b0, 14);

    // Range-check boundaries; with checks off these take the full path.
    run("s_eq_q", 8'd11, 8'd5, 8'd1, 4'd0, !RC, RC, RC ? 1 : 14);
    run("s_eq_q_g", 8'd11, 8'd18, 8'd12, 4'd7, 1'b0, RC, RC ? 1 : 14);
    run("r_zero", 8'd4, 8'd18, 8'd0, 4'd7, 1'b0, RC, RC ? 1 : 14);
    run("pub_zero", 8'd2, 8'd0, 8'd5, 4'd3, 1'b0, RC, RC ? 1 : 14);
    run("r_eq_p", 8'd4, 8'd18, 8'd23, 4'd7, 1'b0, RC, RC ? 1 : 14);
    run("good2", 8'd4, 8'd18, 8'd12, 4'd7, 1'b1, 1'b0, 14);

    // Clear in IDLE drops a held valid.
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    check("clr_idle_valid", valid, 1'b0);

    // Start held through busy with operands changed mid-run.
    launch(8'd4, 8'd18, 8'd12, 4'd7, 1'b1);
    s_in = 8'd5;
    wait_done(lat, bcnt);
    check("hs_lat", lat, 14);
    check("hs_valid", valid, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    check("hs_restart_busy", busy, 1'b1);
    check("hs_restart_done", done, 1'b0);
    wait_done(lat, bcnt);
    check("hs2_lat", lat, 14);
    check("hs2_valid", valid, 1'b0);

    // Abort at T+5.
    launch(8'd4, 8'd18, 8'd12, 4'd7, 1'b0);
    repeat (4) @(posedge clk);
    #1; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("abort_busy", busy, 1'b0);
    npulse = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) npulse++;
    end
    check("abort_nodone", npulse, 0);

    // Clear and start together: start dropped.
    @(negedge clk); clear = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; start = 1'b0;
    check("clr_start_busy", busy, 1'b0);
    npulse = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) npulse++;
    end
    check("clr_start_nodone", npulse, 0);

    // Async reset mid EXP_C.
    launch(8'd4, 8'd18, 8'd12, 4'd7, 1'b0);
    repeat (10) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_valid", valid, 1'b0);
    check("mid_rst_err", err, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    run("after_rst", 8'd4, 8'd18, 8'd12, 4'd7, 1'b1, 1'b0, 14);

    // Default-parameter instance: x=12345, k=999, c=0xBEEF.
    bx   = 64'd12345;
    bk   = 64'd999;
    bcc  = 64'hBEEF;
    bsig = (bk + bcc * bx) % BQ;
    bpk  = modpow(64'd7, bx, BP);
    brr  = modpow(64'd7, bk, BP);
    run_big("big_good", bsig, bpk, brr, bcc, 1'b1);
    run_big("big_bad", bsig + 1, bpk, brr, bcc, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
